dataint_chksum_checker: RTL and testbench
=========================================

DATAINT_CHKSUM_CHECKER -- requirements
Module: dataint_chksum_checker

Interface
REQ-001 Parameter WIDTH, default 8: data and checksum width in bits.
REQ-002 Parameter MAX_BEATS, default 256: maximum payload beats per packet, excluding the trailing checksum beat.
REQ-003 Parameter CNT_WIDTH, default 16: error counter width.
REQ-004 i_clk  input  1  clock; all state updates on the rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_valid  input  1  upstream beat valid.
REQ-007 o_ready  output  1  beat accepted when i_valid && o_ready.
REQ-008 i_data  input  WIDTH  payload beat, or expected checksum on the last beat.
REQ-009 i_last  input  1  marks the final beat, which carries the expected checksum.
REQ-010 o_done  output  1  one-cycle pulse: packet verdict available.
REQ-011 o_pass  output  1  registered verdict; checksum matched and length legal.
REQ-012 o_fail  output  1  registered verdict; mismatch or length error.
REQ-013 o_len_err  output  1  registered; last packet exceeded MAX_BEATS.
REQ-014 o_busy  output  1  high while a packet is partially received or being reported.
REQ-015 o_err_count  output  CNT_WIDTH  count of failed packets.

Function
REQ-016 FSM states: IDLE, ACCUM, REPORT.
  - IDLE -> ACCUM on an accepted non-last beat.
  - IDLE or ACCUM -> REPORT on an accepted last beat.
  - REPORT -> IDLE unconditionally after 1 cycle.
REQ-017 o_ready = 1 in IDLE and ACCUM, 0 in REPORT; i_valid in REPORT is not consumed.
REQ-018 Accepted non-last beat: sum <= sum + i_data, modulo 2^WIDTH (carry discarded); beat count increments.
REQ-019 Beat counter is clog2(MAX_BEATS+2) bits and saturates at MAX_BEATS+1; a count of MAX_BEATS+1 sets the packet length-error flag.
REQ-020 Accepted last beat: i_data is not added; compare i_data to the sum of preceding payload beats.
  - pass = (match && !len_err).
  - Registered into o_pass, o_fail = !pass, and o_len_err.
REQ-021 Latency: last beat accepted at edge N -> o_done = 1 and verdict valid for the cycle after edge N; o_ready returns to 1 after edge N+1.
REQ-022 o_pass, o_fail and o_len_err hold their values until the next o_done; they are never simultaneously high except o_fail with o_len_err.
REQ-023 Zero-payload packet (a last beat accepted in IDLE): expected sum 0.
REQ-024 Entering REPORT clears sum, beat count and length flag, so the next packet starts clean.
REQ-025 o_busy = (state != IDLE).

Reset
REQ-026 Asserting i_rst_n low immediately forces:
  - state IDLE, sum 0, beat count 0, length flag 0;
  - o_done 0, o_pass 0, o_fail 0, o_len_err 0, o_err_count 0;
  - o_ready 1 once released.
REQ-027 Reset mid-packet discards the partial packet and produces no o_done.

Configuration
REQ-028 Macro DATAINT_CHKSUM_ERR_CNT_EN.
  - Defined: o_err_count increments by 1 on each o_done with o_fail = 1, saturating at 2^CNT_WIDTH-1.
  - Undefined: no counter logic; o_err_count is tied to 0.

Verification
REQ-029 WIDTH=8: payload 0x10, 0x20, 0x30, then last 0x60 -> o_done pulse 1 cycle after the last beat, o_pass=1, o_fail=0, o_ready low that cycle.
REQ-030 Payload 0xF0, 0x20, then last 0x10 (sum wraps) -> o_pass=1.
REQ-031 Payload 0x01, then last 0x02 -> o_fail=1, o_len_err=0; o_err_count=1 with macro, 0 without.
REQ-032 Last-only 0x00 -> o_pass=1; then last-only 0x05 -> o_fail=1; i_valid held high through REPORT, with no beat lost or double-counted.
REQ-033 MAX_BEATS=4: five payload beats 0x01, then last 0x05 -> o_fail=1, o_len_err=1.
REQ-034 Reset asserted after two payload beats, released, then payload 0x03 and last 0x03 -> no o_done during reset, then o_pass=1.

Source files
------------

// File: rtl/dataint_chksum_checker.sv
// Streaming checksum checker.
// Payload beats are summed modulo 2^WIDTH. The final beat (i_last) carries
// the expected checksum. A one-cycle o_done pulse reports whether the packet
// matched and stayed within MAX_BEATS payload beats.
// Optional feature: define DATAINT_CHKSUM_ERR_CNT_EN to enable a saturating
// count of failed packets on o_err_count. When it is undefined, o_err_count
// is tied to zero.
module dataint_chksum_checker #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 256,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_last,
  output logic                 o_done,
  output logic                 o_pass,
  output logic                 o_fail,
  output logic                 o_len_err,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_err_count
);

  // The counter needs room for one value past MAX_BEATS, which marks an overlong packet.
  localparam int unsigned     BeatW   = $clog2(MAX_BEATS + 2);
  localparam logic [BeatW-1:0] BeatSat = BeatW'(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StReport
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [BeatW-1:0] beats_q, beats_d;
  logic             len_q, len_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             len_err_q, len_err_d;

  logic accept;
  logic accept_data;
  logic accept_last;
  logic match;

  assign o_ready     = (state_q != StReport);
  assign o_busy      = (state_q != StIdle);
  assign accept      = i_valid && o_ready;
  assign accept_data = accept && !i_last;
  assign accept_last = accept && i_last;
  assign match       = (i_data == sum_q);

  // Next-state logic: one cycle in REPORT, then back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept_last) begin
          state_d = StReport;
        end else if (accept_data) begin
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (accept_last) begin
          state_d = StReport;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Accumulator, beat counter and length flag. A last beat clears them for the next packet.
  always_comb begin
    sum_d   = sum_q;
    beats_d = beats_q;
    len_d   = len_q;
    if (accept_last) begin
      sum_d   = '0;
      beats_d = '0;
      len_d   = 1'b0;
    end else if (accept_data) begin
      sum_d = sum_q + i_data;
      if (beats_q != BeatSat) begin
        beats_d = beats_q + BeatW'(1);
      end
      len_d = len_q || (beats_d == BeatSat);
    end
  end

  // Verdict: captured on the last beat and held until the next last beat.
  always_comb begin
    done_d    = accept_last;
    pass_d    = pass_q;
    fail_d    = fail_q;
    len_err_d = len_err_q;
    if (accept_last) begin
      pass_d    = match && !len_q;
      fail_d    = !(match && !len_q);
      len_err_d = len_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      sum_q     <= '0;
      beats_q   <= '0;
      len_q     <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      beats_q   <= beats_d;
      len_q     <= len_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      len_err_q <= len_err_d;
    end
  end

  assign o_done    = done_q;
  assign o_pass    = pass_q;
  assign o_fail    = fail_q;
  assign o_len_err = len_err_q;

`ifdef DATAINT_CHKSUM_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // Count failed verdicts while o_done is high. The counter saturates at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (done_q && fail_q && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Error counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_count = err_cnt_q;
`else
  assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_dataint_chksum_checker.sv
// Self-checking bench for dataint_chksum_checker.
// The driver pushes a reference verdict for each packet. The monitor pops and
// compares that verdict on every o_done pulse.
module tb_dataint_chksum_checker;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned CNT_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 valid = 1'b0;
  logic                 last = 1'b0;
  logic [WIDTH-1:0]     data = '0;
  logic                 ready;
  logic                 done;
  logic                 pass;
  logic                 fail;
  logic                 len_err;
  logic                 busy;
  logic [CNT_WIDTH-1:0] err_count;

  dataint_chksum_checker #(
    .WIDTH    (WIDTH),
    .MAX_BEATS(MAX_BEATS),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_data     (data),
    .i_last     (last),
    .o_done     (done),
    .o_pass     (pass),
    .o_fail     (fail),
    .o_len_err  (len_err),
    .o_busy     (busy),
    .o_err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pass;
    logic fail;
    logic len_err;
  } verdict_t;

  verdict_t exp_q[$];
  int       n_checks = 0;
  int       n_fail = 0;
  int       model_fails = 0;
  bit       cnt_check_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_err_count(input int fails);
`ifdef DATAINT_CHKSUM_ERR_CNT_EN
    int cap = (1 << CNT_WIDTH) - 1;
    return (fails > cap) ? cap : fails;
`else
    return 0;
`endif
  endfunction

  // Monitor: compare the verdict on each done pulse, and check that held outputs stay stable.
  initial begin
    verdict_t held;
    verdict_t e;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = '0;
        cnt_check_pending = 1'b0;
        check("done_during_reset", 32'(done), 32'd0);
      end else if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("verdict_pass", 32'(pass), 32'(e.pass));
          check("verdict_fail", 32'(fail), 32'(e.fail));
          check("verdict_len_err", 32'(len_err), 32'(e.len_err));
          check("ready_low_in_report", 32'(ready), 32'd0);
          check("busy_in_report", 32'(busy), 32'd1);
          held = e;
          if (e.fail) model_fails++;
          cnt_check_pending = 1'b1;
        end
      end else begin
        check("verdict_held", 32'({pass, fail, len_err}), 32'(held));
        if (cnt_check_pending) begin
          check("err_count", 32'(err_count), 32'(exp_err_count(model_fails)));
          cnt_check_pending = 1'b0;
        end
      end
    end
  end

  // Present one beat and keep it on the bus until the DUT accepts it.
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic l);
    int w = 0;
    @(negedge clk);
    valid = 1'b1;
    data  = d;
    last  = l;
    while (!ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic idle_gap(input int cycles);
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // Send a packet and push the reference verdict, computed from the whole packet.
  task automatic send_packet(input logic [WIDTH-1:0] payload[$], input logic [WIDTH-1:0] chk,
                             input bit gaps);
    int       total = 0;
    logic     len_bad;
    logic     ok;
    verdict_t v;
    foreach (payload[i]) begin
      total += int'(payload[i]);
      if (gaps && ($urandom_range(0, 3) == 0)) idle_gap($urandom_range(0, 2));
      send_beat(payload[i], 1'b0);
    end
    send_beat(chk, 1'b1);
    len_bad = (payload.size() > MAX_BEATS);
    ok      = ((total % (1 << WIDTH)) == int'(chk)) && !len_bad;
    v.pass    = ok;
    v.fail    = !ok;
    v.len_err = len_bad;
    exp_q.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] pl[$];
    logic [WIDTH-1:0] chk;
    int               s;

    // Reset values while reset is asserted.
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 32'(ready), 32'd1);

    // Three beats that sum exactly; check the latency of the done pulse.
    pl = '{8'h10, 8'h20, 8'h30};
    send_packet(pl, 8'h60, 1'b0);
    #1;
    check("latency_done_high", 32'(done), 32'd1);
    check("latency_ready_low", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    check("latency_done_low", 32'(done), 32'd0);
    check("latency_ready_back", 32'(ready), 32'd1);

    // The sum wraps modulo 2^WIDTH.
    pl = '{8'hF0, 8'h20};
    send_packet(pl, 8'h10, 1'b0);

    // Checksum mismatch.
    pl = '{8'h01};
    send_packet(pl, 8'h02, 1'b0);

    // Back-to-back last-only packets with valid held high through REPORT.
    pl.delete();
    send_packet(pl, 8'h00, 1'b0);
    send_packet(pl, 8'h05, 1'b0);

    // Too many beats: five payload beats against MAX_BEATS=4.
    pl = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    send_packet(pl, 8'h05, 1'b0);

    // Far too many beats: the beat counter saturates and the length error stays set.
    pl = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    send_packet(pl, 8'h09, 1'b0);

    // Randomised packets, mostly with a correct checksum, with random idle gaps.
    for (int p = 0; p < 80; p++) begin
      pl.delete();
      s = 0;
      for (int b = 0; b < int'($urandom_range(0, 6)); b++) begin
        pl.push_back(WIDTH'($urandom));
        s += int'(pl[b]);
      end
      chk = ($urandom_range(0, 9) < 7) ? WIDTH'(s) : WIDTH'($urandom);
      send_packet(pl, chk, 1'b1);
      if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(0, 3));
    end
    idle_gap(4);

    // Reset in the middle of a packet: the partial packet is discarded and no done is produced.
    send_beat(8'h07, 1'b0);
    send_beat(8'h09, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pass", 32'(pass), 32'd0);
    check("midrst_fail", 32'(fail), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    repeat (3) @(negedge clk);
    model_fails = 0;
    rst_n = 1'b1;
    check("midrst_ready", 32'(ready), 32'd1);
    pl = '{8'h03};
    send_packet(pl, 8'h03, 1'b0);

    idle_gap(5);
    check("pending_verdicts", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
